// File: rtl/zion_basic_circuit_lib_demux_onehot_stream.sv
// Valid/ready onehot stream demultiplexer with one registered holding stage.
// Optional saturating dropped-beat counter (oErrCnt) is built when ZION_DEMUX_ONEHOT_ERRCNT_EN is defined.
module zion_basic_circuit_lib_demux_onehot_stream #(
  parameter int NUM_PORT  = 4,
  parameter int WIDTH_DAT = 8
`ifdef ZION_DEMUX_ONEHOT_ERRCNT_EN
  ,
  parameter int ERR_CNT_W = 8
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iVld,
  output logic                          oRdy,
  input  logic [NUM_PORT-1:0]           iSel,
  input  logic [WIDTH_DAT-1:0]          iDat,
  output logic [NUM_PORT-1:0]           oVld,
  input  logic [NUM_PORT-1:0]           iRdy,
  output logic [NUM_PORT*WIDTH_DAT-1:0] oDat,
  output logic                          oErr
`ifdef ZION_DEMUX_ONEHOT_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0]          oErrCnt
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]           state;
  logic [NUM_PORT-1:0]  sel_reg;
  logic [WIDTH_DAT-1:0] dat_reg;

  logic vld_reg;
  logic drain;
  logic accept;
  logic sel_legal;
  logic load;
  logic drop;

  assign vld_reg = (state == ST_FULL);

  // Only the addressed port's ready can release the beat.
  assign drain  = vld_reg && ((sel_reg & iRdy) != '0);
  assign oRdy   = !vld_reg || drain;
  assign accept = iVld && oRdy;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign sel_legal = (iSel != '0) && ((iSel & (iSel - NUM_PORT'(1))) == '0);
  assign load      = accept && sel_legal;
  assign drop      = accept && !sel_legal;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data and select are reset too, so oDat reads all-zero straight after reset.
      state   <= ST_EMPTY;
      sel_reg <= '0;
      dat_reg <= '0;
      oErr    <= 1'b0;
    end else begin
      oErr <= drop;
      if (load) begin
        state   <= ST_FULL;
        sel_reg <= iSel;
        dat_reg <= iDat;
      end else if (drain) begin
        state <= ST_EMPTY;
      end
    end
  end

  assign oVld = {NUM_PORT{vld_reg}} & sel_reg;

  // NOTE: oDat gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    oDat = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (sel_reg[i]) oDat[i*WIDTH_DAT +: WIDTH_DAT] = dat_reg;
    end
  end

`ifdef ZION_DEMUX_ONEHOT_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      oErrCnt <= '0;
    end else if (drop && (oErrCnt != '1)) begin
      oErrCnt <= oErrCnt + ERR_CNT_W'(1);
    end
  end
`endif

`ifndef SYNTHESIS
  // A stalled producer must not change the offered beat.
  property p_stall_stable;
    @(posedge clk) disable iff (rst)
      (iVld && !oRdy) |=> (!iVld || ($stable(iSel) && $stable(iDat)));
  endproperty
  a_stall_stable: assert property (p_stall_stable);
`endif

endmodule

// File: tb/tb_zion_basic_circuit_lib_demux_onehot_stream.sv
// Scoreboard bench for the onehot stream demux: a queue-based reference model predicts
// every output each cycle; randomized and directed stimulus runs independently of the checker.
module tb_zion_basic_circuit_lib_demux_onehot_stream;

  localparam int NUM_PORT  = 4;
  localparam int WIDTH_DAT = 8;
  localparam int ERR_CNT_W = 8;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          iVld = 1'b0;
  logic                          oRdy;
  logic [NUM_PORT-1:0]           iSel = '0;
  logic [WIDTH_DAT-1:0]          iDat = '0;
  logic [NUM_PORT-1:0]           oVld;
  logic [NUM_PORT-1:0]           iRdy = '0;
  logic [NUM_PORT*WIDTH_DAT-1:0] oDat;
  logic                          oErr;
`ifdef ZION_DEMUX_ONEHOT_ERRCNT_EN
  logic [ERR_CNT_W-1:0]          oErrCnt;
`endif

  zion_basic_circuit_lib_demux_onehot_stream dut (
    .clk    (clk),
    .rst    (rst),
    .iVld   (iVld),
    .oRdy   (oRdy),
    .iSel   (iSel),
    .iDat   (iDat),
    .oVld   (oVld),
    .iRdy   (iRdy),
    .oDat   (oDat),
    .oErr   (oErr)
`ifdef ZION_DEMUX_ONEHOT_ERRCNT_EN
    ,
    .oErrCnt(oErrCnt)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_PORT-1:0]  sel;
    logic [WIDTH_DAT-1:0] dat;
  } beat_t;

  beat_t exp_q[$];
  int    checks    = 0;
  int    errors    = 0;
  bit    exp_err   = 1'b0;
  bit    fresh     = 1'b1;
  int    exp_cnt   = 0;
  int    delivered = 0;

  logic [NUM_PORT-1:0] rdy_fixed  = '1;
  bit                  rdy_random = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Downstream ready: fixed pattern or random per cycle; changes away from both edges.
  initial forever begin
    @(posedge clk);
    #2;
    iRdy = rdy_random ? NUM_PORT'($urandom) : rdy_fixed;
  end

  // Monitor + reference model: compare, then advance the model for the coming edge.
  always @(negedge clk) begin : monitor
    logic [NUM_PORT-1:0]           ev;
    logic [NUM_PORT*WIDTH_DAT-1:0] ed;
    bit                            drain;
    bit                            rdy;
    ev = '0;
    ed = '0;
    if (exp_q.size() > 0) begin
      ev = exp_q[0].sel;
      for (int i = 0; i < NUM_PORT; i++)
        if (exp_q[0].sel[i]) ed[i*WIDTH_DAT +: WIDTH_DAT] = exp_q[0].dat;
    end
    drain = (exp_q.size() > 0) && ((exp_q[0].sel & iRdy) != '0);
    rdy   = (exp_q.size() == 0) || drain;

    check("oVld", 64'(oVld), 64'(ev));
    check("oRdy", 64'(oRdy), 64'(rdy));
    check("oErr", 64'(oErr), 64'(exp_err));
    if (exp_q.size() > 0 || fresh) check("oDat", 64'(oDat), 64'(ed));
`ifdef ZION_DEMUX_ONEHOT_ERRCNT_EN
    check("oErrCnt", 64'(oErrCnt), 64'(exp_cnt));
`endif

    if (rst) begin
      exp_q.delete();
      exp_err = 1'b0;
      fresh   = 1'b1;
      exp_cnt = 0;
    end else begin
      exp_err = 1'b0;
      if (drain) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (iVld && rdy) begin
        if ($countones(iSel) == 1) begin
          exp_q.push_back(beat_t'{sel: iSel, dat: iDat});
          fresh = 1'b0;
        end else begin
          exp_err = 1'b1;
          if (exp_cnt < (1 << ERR_CNT_W) - 1) exp_cnt++;
        end
      end
    end
  end

  // Offer one beat and hold it until accepted; returns at posedge+1 so beats can be back-to-back.
  task automatic send(input logic [NUM_PORT-1:0] sel, input logic [WIDTH_DAT-1:0] dat);
    bit ok;
    ok   = 1'b0;
    iVld = 1'b1;
    iSel = sel;
    iDat = dat;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      ok = oRdy;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout at %0t: oRdy stayed %0b, required 1", $time, oRdy);
    end
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with scrambled sel/data to show they are ignored without a handshake.
  task automatic idle(input int n);
    iVld = 1'b0;
    for (int k = 0; k < n; k++) begin
      iSel = NUM_PORT'($urandom);
      iDat = WIDTH_DAT'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NUM_PORT-1:0] rand_legal();
    return NUM_PORT'(1) << $urandom_range(0, NUM_PORT - 1);
  endfunction

  function automatic logic [NUM_PORT-1:0] rand_illegal();
    logic [NUM_PORT-1:0] s;
    do s = NUM_PORT'($urandom); while ($countones(s) == 1);
    return s;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single beat to port 2, drained the cycle it appears.
    rdy_fixed = 4'b0100;
    send(4'b0100, 8'hA5);
    idle(2);

    // Back-to-back beats to every port with all ready.
    rdy_fixed = 4'b1111;
    send(4'b0001, 8'h10);
    send(4'b0010, 8'h21);
    send(4'b0100, 8'h42);
    send(4'b1000, 8'h83);
    idle(2);

    // Port 1 stalled while other readies are high; a second beat waits behind it.
    rdy_fixed = 4'b1101;
    send(4'b0010, 8'h3C);
    idle(4);
    fork
      send(4'b1000, 8'h77);
      begin
        repeat (3) @(posedge clk);
        rdy_fixed = 4'b1111;
      end
    join
    idle(3);

    // Illegal selects: two bits, none, all.
    send(4'b0110, 8'h11);
    idle(2);
    send(4'b0000, 8'h22);
    send(4'b1111, 8'h33);
    send(4'b0001, 8'h44);
    idle(2);

    // Reset while full discards the held beat.
    rdy_fixed = 4'b0000;
    send(4'b0100, 8'h5A);
    idle(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_fixed = 4'b1111;
    idle(3);

    // Counter saturation: more than 2^ERR_CNT_W dropped beats under random ready.
    rdy_random = 1'b1;
    for (int n = 0; n < 260; n++) send(rand_illegal(), WIDTH_DAT'($urandom));
    idle(2);

    // Random mix of legal/illegal beats, random gaps and random ready.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 8) send(rand_legal(), WIDTH_DAT'($urandom));
      else                          send(rand_illegal(), WIDTH_DAT'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    rdy_random = 1'b0;
    rdy_fixed  = 4'b1111;
    idle(6);
    check("beats_delivered_nonzero", 64'(delivered > 300), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
